// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_RESP     = 2'd2
    } fetch_state_t;

    localparam logic [3:0] RTYPE_LOAD     = 4'b0000;
    localparam logic [3:0] RTYPE_IFILL    = 4'b0001;
    localparam logic [3:0] RTYPE_FILL_ALT = 4'b0100;
    localparam logic [3:0] RTYPE_WAKEUP   = 4'b0111;

    localparam logic [4:0] RQTYPE_IFILL = 5'd0;
    localparam logic [2:0] RQSIZE_LINE  = 3'b100;

    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h00000033;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h40000000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        misaligned;
    } fetch_entry_t;

    // L1.5 returns words big-endian; the core wants little-endian instructions.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: writes 0..4 consecutive entries per cycle, pops one.
// A flush empties the buffer and may load new entries starting at slot 0 in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               flush,
    input  logic [2:0]         enq_cnt,
    input  fetch_entry_t [3:0] enq_entry,
    input  logic               deq,
    output logic               empty,
    output fetch_entry_t       head,
    output logic [CW-1:0]      count
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_base;
    logic          deq_fire;

    assign empty    = (count == '0);
    assign deq_fire = deq && !empty && !flush;
    assign wr_base  = flush ? '0 : wr_ptr;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_base + PW'(enq_cnt);
            if (flush) begin
                rd_ptr <= '0;
                count  <= CW'(enq_cnt);
            end else begin
                if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(enq_cnt) - CW'(deq_fire);
            end
        end
    end

    // Storage carries no reset; the top masks the head while the buffer is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < enq_cnt) mem[wr_base + PW'(i)] <= enq_entry[i];
        end
    end

endmodule

// File: rtl/fetch_buffer_unit.sv
// Instruction fetch front end: requests 16-byte lines from the L1.5 and
// queues the returned instructions for decode, with redirect/flush support.
module fetch_buffer_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        deq_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_misaligned,
    output logic [4:0]  transducer_l15_rqtype,
    output logic [2:0]  transducer_l15_size,
    output logic [31:0] transducer_l15_address,
    output logic        transducer_l15_val,
    input  logic        l15_transducer_header_ack,
    input  logic        l15_transducer_ack,
    input  logic        l15_transducer_val,
    input  logic [63:0] l15_transducer_data_0,
    input  logic [63:0] l15_transducer_data_1,
    input  logic [3:0]  l15_transducer_returntype,
    output logic        transducer_l15_req_ack,
    output logic [1:0]  state_reg
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Request handshake: a request transfers when transducer_l15_val and
    // l15_transducer_header_ack are both high; l15_transducer_ack (same or later
    // cycle) means the line is in flight; the response is consumed in the cycle
    // transducer_l15_req_ack is high.
    fetch_state_t state, state_next;
    logic [31:2]  fetch_pc;
    logic         wake_up;
    logic         discard;
    logic         halted;

    logic         is_fetch_rt;
    logic         resp_valid;
    logic         resp_take;
    logic         resp_enq;
    logic         wakeup_msg;
    logic         req_val;
    logic         req_fire;
    logic         discard_set;
    logic         redirect_misaligned;
    logic [1:0]   start_idx;
    logic [31:0]  line_words [4];

    logic [CW-1:0]      count;
    logic [CW-1:0]      free_cnt;
    logic [CW-1:0]      need_cnt;
    logic               fifo_empty;
    logic               fifo_deq;
    logic [2:0]         enq_cnt;
    fetch_entry_t [3:0] enq_entry;
    fetch_entry_t       head;

    assign is_fetch_rt = (l15_transducer_returntype == RTYPE_LOAD)  ||
                         (l15_transducer_returntype == RTYPE_IFILL) ||
                         (l15_transducer_returntype == RTYPE_FILL_ALT);
    assign resp_valid  = l15_transducer_val && is_fetch_rt;
    assign wakeup_msg  = l15_transducer_val && (l15_transducer_returntype == RTYPE_WAKEUP);
    assign resp_take   = resp_valid && (state == S_RESP);
    assign resp_enq    = resp_take && !discard && !redirect_valid;
    assign req_fire    = req_val && l15_transducer_header_ack;

    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // A redirect orphans the line only if its response is still to come after this edge.
    assign discard_set = redirect_valid &&
                         (req_fire || (state == S_WAIT_ACK) || ((state == S_RESP) && !resp_valid));

    assign start_idx = fetch_pc[3:2];
    assign free_cnt  = CW'(DEPTH) - count;
    assign need_cnt  = CW'(3'd4 - {1'b0, start_idx});

    assign line_words[0] = byte_swap32(l15_transducer_data_0[63:32]);
    assign line_words[1] = byte_swap32(l15_transducer_data_0[31:0]);
    assign line_words[2] = byte_swap32(l15_transducer_data_1[63:32]);
    assign line_words[3] = byte_swap32(l15_transducer_data_1[31:0]);

    always_comb begin
        state_next = state;
        req_val    = 1'b0;
        case (state)
            S_REQ: begin
                req_val = wake_up && !halted && (free_cnt >= need_cnt);
                if (req_val && l15_transducer_header_ack)
                    state_next = l15_transducer_ack ? S_RESP : S_WAIT_ACK;
            end
            S_WAIT_ACK: if (l15_transducer_ack) state_next = S_RESP;
            S_RESP:     if (resp_valid) state_next = S_REQ;
            default:    state_next = S_REQ;
        endcase
    end

    always_comb begin
        logic [1:0] idx;
        idx       = '0;
        enq_cnt   = 3'd0;
        enq_entry = '0;
        if (redirect_valid) begin
            if (wake_up && redirect_misaligned) begin
                enq_cnt      = 3'd1;
                enq_entry[0] = {NOP_INSTR, redirect_pc, 1'b1};
            end
        end else if (resp_enq) begin
            enq_cnt = 3'd4 - {1'b0, start_idx};
            for (int k = 0; k < 4; k++) begin
                idx          = start_idx + 2'(k);
                enq_entry[k] = {line_words[idx], fetch_pc[31:4], idx, 2'b00, 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC[31:2];
            wake_up  <= 1'b0;
            discard  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state <= state_next;
            if (wakeup_msg) wake_up <= 1'b1;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc[31:2];
                halted   <= wake_up && redirect_misaligned;
            end else if (resp_enq) begin
                fetch_pc <= {fetch_pc[31:4] + 28'd1, 2'b00};
            end
            if (discard_set)    discard <= 1'b1;
            else if (resp_take) discard <= 1'b0;
        end
    end

    assign fifo_deq = deq_ready && instr_valid && !redirect_valid;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (redirect_valid),
        .enq_cnt   (enq_cnt),
        .enq_entry (enq_entry),
        .deq       (fifo_deq),
        .empty     (fifo_empty),
        .head      (head),
        .count     (count)
    );

    assign instr_valid      = !fifo_empty;
    assign instr            = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc         = instr_valid ? head.pc : 32'd0;
    assign instr_misaligned = instr_valid && head.misaligned;

    assign transducer_l15_val     = req_val;
    assign transducer_l15_rqtype  = RQTYPE_IFILL;
    assign transducer_l15_size    = RQSIZE_LINE;
    assign transducer_l15_address = {fetch_pc[31:4], 4'b0000};
    // Fetch-type responses wait for S_WAIT_ACK to clear; everything else drains at once.
    assign transducer_l15_req_ack = nrst && l15_transducer_val &&
                                    (!is_fetch_rt || (state != S_WAIT_ACK));
    assign state_reg = state;

endmodule
